// File: rtl/turkey_counter_n.sv
// turkey_counter_n: parametrised up/down event counter for the sensor front end.
// Counts up/dw requests into a WIDTH-bit register with parallel load, wrap or
// saturate at the limits, optional rising-edge qualification of the inputs,
// sticky overflow/underflow flags and a peak-count register.
//
// Ports:
//   clk        system clock, all state updates on its rising edge
//   R          synchronous reset, active-high
//   up, dw     increment / decrement requests
//   ld, din    load strobe and load value (Q <= din)
//   clr_flags  clears OVF/UNF and re-seeds PEAK with the next count
//   Q          current count
//   UTC, DTC   terminal counts (Q all ones / Q zero), combinational from Q
//   Z          zero flag, identical to DTC
//   OVF, UNF   sticky overflow / underflow
//   PEAK       highest value Q has held since reset or clr_flags
module turkey_counter_n #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SATURATE  = 1'b0,
  parameter bit          EDGE_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             R,
  input  logic             up,
  input  logic             dw,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] Q,
  output logic             UTC,
  output logic             DTC,
  output logic             Z,
  output logic             OVF,
  output logic             UNF,
  output logic [WIDTH-1:0] PEAK
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] peak_q, peak_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             up_q, dw_q;
  logic             up_e, dw_e;
  logic             inc, dec;

  // Previous-cycle copies of up/dw; cleared by reset so an input held high
  // through reset release is seen as a fresh rising edge.
  always_comb begin
    up_e = up;
    dw_e = dw;
    if (EDGE_MODE) begin
      up_e = up & ~up_q;
      dw_e = dw & ~dw_q;
    end
  end

  // Simultaneous up and down events cancel.
  assign inc = up_e & ~dw_e;
  assign dec = dw_e & ~up_e;

  always_comb begin
    cnt_d = cnt_q;
    // A clear and a new event on the same edge: the set below wins.
    ovf_d = ovf_q & ~clr_flags;
    unf_d = unf_q & ~clr_flags;
    if (ld) begin
      cnt_d = din;
    end else if (inc) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
        cnt_d = SATURATE ? CNT_MAX : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec) begin
      if (cnt_q == '0) begin
        unf_d = 1'b1;
        cnt_d = SATURATE ? '0 : CNT_MAX;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    // Tracking the next count (not the current one) keeps PEAK >= Q.
    if (clr_flags) begin
      peak_d = cnt_d;
    end else if (cnt_d > peak_q) begin
      peak_d = cnt_d;
    end else begin
      peak_d = peak_q;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      cnt_q  <= '0;
      peak_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      up_q   <= 1'b0;
      dw_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      up_q   <= up;
      dw_q   <= dw;
    end
  end

  assign Q    = cnt_q;
  assign UTC  = (cnt_q == CNT_MAX);
  assign DTC  = (cnt_q == '0);
  assign Z    = DTC;
  assign OVF  = ovf_q;
  assign UNF  = unf_q;
  assign PEAK = peak_q;

endmodule

// File: tb/tb_turkey_counter_n.sv
// Bench for turkey_counter_n: four instances (WIDTH=8, every SATURATE x
// EDGE_MODE combination) share one stimulus stream and are compared every
// cycle against an arithmetic model of the counting rules.
module tb_turkey_counter_n;

  localparam int NI  = 4;
  localparam int MAXV = 255;

  logic       clk = 1'b0;
  logic       R = 1'b0, up = 1'b0, dw = 1'b0, ld = 1'b0, clr_flags = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] q_o [NI];
  logic [7:0] peak_o [NI];
  logic       utc_o [NI], dtc_o [NI], z_o [NI], ovf_o [NI], unf_o [NI];

  int n_checks = 0;
  int n_fail   = 0;

  // model state per instance
  int m_q [NI], m_peak [NI];
  bit m_ovf [NI], m_unf [NI], m_pu [NI], m_pd [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam bit SAT = (g % 2) == 1;
    localparam bit EDG = (g / 2) == 1;
    turkey_counter_n #(.WIDTH(8), .SATURATE(SAT), .EDGE_MODE(EDG)) u_dut (
      .clk       (clk),
      .R         (R),
      .up        (up),
      .dw        (dw),
      .ld        (ld),
      .din       (din),
      .clr_flags (clr_flags),
      .Q         (q_o[g]),
      .UTC       (utc_o[g]),
      .DTC       (dtc_o[g]),
      .Z         (z_o[g]),
      .OVF       (ovf_o[g]),
      .UNF       (unf_o[g]),
      .PEAK      (peak_o[g])
    );
  end

  task automatic check(input string tag, input int k, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d got=0x%0h exp=0x%0h t=%0t", tag, k, got, exp, $time);
    end
  endtask

  // Apply one clock edge of the counting rules to instance k.
  task automatic model_edge(input int k);
    bit sat, edg, ue, de, so, su;
    int nq;
    sat = (k % 2) == 1;
    edg = (k / 2) == 1;
    if (R) begin
      m_q[k] = 0; m_peak[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      m_pu[k] = 0; m_pd[k] = 0;
      return;
    end
    ue = edg ? (up && !m_pu[k]) : up;
    de = edg ? (dw && !m_pd[k]) : dw;
    m_pu[k] = up;
    m_pd[k] = dw;
    nq = m_q[k];
    so = 0; su = 0;
    if (ld) nq = int'(din);
    else if (ue && !de) begin
      if (m_q[k] == MAXV) begin so = 1; nq = sat ? MAXV : 0; end
      else nq = m_q[k] + 1;
    end else if (de && !ue) begin
      if (m_q[k] == 0) begin su = 1; nq = sat ? 0 : MAXV; end
      else nq = m_q[k] - 1;
    end
    m_ovf[k] = (clr_flags ? 1'b0 : m_ovf[k]) | so;
    m_unf[k] = (clr_flags ? 1'b0 : m_unf[k]) | su;
    m_peak[k] = clr_flags ? nq : ((nq > m_peak[k]) ? nq : m_peak[k]);
    m_q[k] = nq;
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check("Q",    k, int'(q_o[k]),    m_q[k]);
      check("PEAK", k, int'(peak_o[k]), m_peak[k]);
      check("OVF",  k, int'(ovf_o[k]),  int'(m_ovf[k]));
      check("UNF",  k, int'(unf_o[k]),  int'(m_unf[k]));
      check("UTC",  k, int'(utc_o[k]),  (m_q[k] == MAXV) ? 1 : 0);
      check("DTC",  k, int'(dtc_o[k]),  (m_q[k] == 0) ? 1 : 0);
      check("Z",    k, int'(z_o[k]),    (m_q[k] == 0) ? 1 : 0);
    end
  endtask

  // Inputs are already driven; take one edge, update model, check mid-cycle.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < NI; k++) model_edge(k);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit r, input bit u, input bit d, input bit l,
                       input logic [7:0] v, input bit c);
    R = r; up = u; dw = d; ld = l; din = v; clr_flags = c;
  endtask

  initial begin
    int snap;
    @(negedge clk);

    // reset
    drive(1, 0, 0, 0, 8'h00, 0);
    step();
    check("rst_q", 0, int'(q_o[0]), 0);
    check("rst_dtc", 0, int'(dtc_o[0]), 1);
    check("rst_z", 0, int'(z_o[0]), 1);
    check("rst_utc", 0, int'(utc_o[0]), 0);

    // up held for 256 edges: full pass through 0..255 and a wrap
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 0, 0, 8'h00, 0);
      step();
      if (i == 254) check("utc_at_max", 0, int'(utc_o[0]), 1);
    end
    check("wrap_q", 0, int'(q_o[0]), 0);
    check("wrap_ovf", 0, int'(ovf_o[0]), 1);
    check("wrap_peak", 0, int'(peak_o[0]), 255);
    check("sat_q", 1, int'(q_o[1]), 255);
    check("edge_q", 2, int'(q_o[2]), 1);

    // saturating underflow: load 1, then down three times
    drive(0, 0, 0, 1, 8'h01, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 8'h00, 0);
      step();
      check("satdn_q", 1, int'(q_o[1]), 0);
      check("satdn_unf", 1, int'(unf_o[1]), (i >= 1) ? 1 : 0);
    end

    // simultaneous up/dw cancel, then load with up asserted
    drive(0, 0, 0, 1, 8'h10, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 8'h00, 0);
      step();
      check("cancel_q", 0, int'(q_o[0]), 8'h10);
      check("cancel_ovf", 0, int'(ovf_o[0]), 0);
    end
    drive(0, 1, 0, 1, 8'hAA, 0);
    step();
    check("ld_q", 0, int'(q_o[0]), 8'hAA);
    check("ld_peak", 0, int'(peak_o[0]), 8'hAA);

    // edge mode: high 10, low 1, high 3 -> two counts
    drive(0, 0, 0, 0, 8'h00, 0);
    step();
    snap = m_q[2];
    for (int i = 0; i < 14; i++) begin
      drive(0, (i != 10), 0, 0, 8'h00, 0);
      step();
    end
    check("edge_adv", 2, int'(q_o[2]), (snap + 2) % 256);

    // clear on the same edge as a wrap: set wins, PEAK re-seeded to 0
    drive(0, 0, 0, 1, 8'hFF, 0);
    step();
    drive(0, 1, 0, 0, 8'h00, 0);
    step();
    drive(0, 0, 0, 1, 8'hFF, 0);
    step();
    drive(0, 1, 0, 0, 8'h00, 1);
    step();
    check("clrset_ovf", 0, int'(ovf_o[0]), 1);
    check("clrset_peak", 0, int'(peak_o[0]), 0);
    drive(0, 0, 0, 0, 8'h00, 1);
    step();
    check("clr_ovf", 0, int'(ovf_o[0]), 0);

    // reset overrides load/count/clear
    drive(0, 0, 0, 1, 8'hFF, 0);
    step();
    drive(0, 1, 0, 0, 8'h00, 0);
    step();
    drive(0, 0, 0, 1, 8'h55, 0);
    step();
    drive(1, 1, 0, 1, 8'hFF, 1);
    step();
    check("rstov_q", 0, int'(q_o[0]), 0);
    check("rstov_peak", 0, int'(peak_o[0]), 0);
    check("rstov_ovf", 0, int'(ovf_o[0]), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 2), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, ($urandom_range(0, 99) < 8),
            8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 5));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/turkey_counter_n.md
Name: turkey_counter_n

Overview:
- Parametrised successor to the 8-bit turkey up/down counter.
- Counts `up`/`dw` events into a WIDTH-bit register.
- Adds:
  - parallel load;
  - selectable wrap or saturate at the limits;
  - optional rising-edge qualification of the sensor inputs;
  - sticky overflow/underflow flags;
  - a peak-count register.
- Sits between the sensor front end and the display/readout logic.

Parameters:
- WIDTH, 8: counter width in bits; legal range ≥ 2.
- SATURATE, 0:
  - 0: wrap at the limits.
  - 1: hold at the limit.
- EDGE_MODE, 0:
  - 0: a level-high `up`/`dw` counts once per clock.
  - 1: only a rising edge of `up`/`dw` counts.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- R  in  1  synchronous reset, active-high
- up  in  1  increment request
- dw  in  1  decrement request
- ld  in  1  load strobe; Q <= din
- din  in  WIDTH  load value
- clr_flags  in  1  clear OVF/UNF; re-seed PEAK
- Q  out  WIDTH  current count
- UTC  out  1  up terminal count: Q == all ones (combinational from Q)
- DTC  out  1  down terminal count: Q == 0 (combinational from Q)
- Z  out  1  zero flag: Q == 0 (kept for compatibility, identical to DTC)
- OVF  out  1  sticky overflow
- UNF  out  1  sticky underflow
- PEAK  out  WIDTH  highest value Q has held since the last reset or clr_flags

Behaviour:
- Reset: on a clock edge with R=1, all of the following clear, regardless of other inputs:
  - Q, OVF, UNF, PEAK = 0;
  - edge-detect registers (up_d, dw_d) = 0.
  - After reset, UTC=0, DTC=1, Z=1.
- Priority per edge: R > ld > count > hold.
- Effective requests:
  - EDGE_MODE=0: up_e = up, dw_e = dw.
  - EDGE_MODE=1: up_e = up & ~up_d, dw_e = dw & ~dw_d.
  - up_d/dw_d are registered copies of up/dw and update every non-reset edge, including during ld.
  - An input held high through reset release counts once, on the first edge after release.
- Count decision:
  - inc = up_e & ~dw_e; dec = dw_e & ~up_e.
  - up_e & dw_e together → hold (the events cancel); no flag change.
- Increment:
  - Q < max: Q <= Q+1.
  - Q == max with SATURATE=0: Q <= 0 and OVF <= 1.
  - Q == max with SATURATE=1: Q holds at max and OVF <= 1.
- Decrement:
  - Q > 0: Q <= Q-1.
  - Q == 0 with SATURATE=0: Q <= max and UNF <= 1.
  - Q == 0 with SATURATE=1: Q holds at 0 and UNF <= 1.
- Load:
  - ld=1: Q <= din on the next edge.
  - up/dw are ignored for Q that cycle and no flags are set.
- Flags:
  - OVF and UNF are sticky until R or clr_flags.
  - If clr_flags and a new overflow/underflow land on the same edge, the set wins.
- PEAK:
  - Each non-reset edge: PEAK <= max(PEAK, Q_next), where Q_next is the value Q takes on that edge. This guarantees PEAK ≥ Q at all times.
  - With clr_flags=1: PEAK <= Q_next.
  - A wrap to 0 does not lower PEAK.
- Latency: Q, OVF, UNF and PEAK reflect a request one clock after it is sampled. UTC, DTC and Z follow Q combinationally.
- Mid-operation reset: R overrides a simultaneous ld, count or clr_flags. Nothing from that cycle survives.

Test Plan:
- WIDTH=8, SATURATE=0: reset, then hold up=1 for 256 clocks → Q steps 0..255, then reads 0; OVF=1 on the wrap edge; PEAK=255; UTC=1 only while Q=255.
- SATURATE=1: load din=0x01, then dw=1 for 3 clocks → Q = 0x00, 0x00, 0x00; UNF=1 from the second edge; DTC=Z=1.
- up=dw=1 for 5 clocks from Q=0x10 → Q stays 0x10; OVF=UNF=0. Then ld=1, din=0xAA with up=1 → Q=0xAA, PEAK=0xAA.
- EDGE_MODE=1: up held high for 10 clocks, then low 1 clock, then high 3 clocks → Q advances by exactly 2.
- OVF=1, then clr_flags=1 on the same edge as another wrap → OVF stays 1; PEAK re-seeded to 0. Next clr_flags alone → OVF=0.
- Q=0x55 with OVF=1 and PEAK=0x80: assert R together with ld=1, din=0xFF → Q=0, PEAK=0, OVF=UNF=0.
